data_bus_uart: RTL

//  Data-side memory subsystem for MCPU. Consumes mem_addr_out/mem_data_out/mem_write/mem_read.

---
 rtl/data_bus_uart_if.sv | 24 ++
 rtl/data_bus_uart.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_bus_uart_if.sv
// Data-side bus between MCPU and the memory subsystem: load/store request levels and load data.
interface data_bus_uart_if;
  logic [15:0] mem_addr_in;
  logic [15:0] mem_data_in;
  logic        mem_write_in;
  logic        mem_read_in;
  logic [15:0] data_out;

  modport master (
    output mem_addr_in,
    output mem_data_in,
    output mem_write_in,
    output mem_read_in,
    input  data_out
  );

  modport slave (
    input  mem_addr_in,
    input  mem_data_in,
    input  mem_write_in,
    input  mem_read_in,
    output data_out
  );
endinterface

// File: rtl/data_bus_uart.sv
// MCPU data-side subsystem: word RAM, memory-mapped 8N1 UART transmitter and free-running
// cycle counter behind an edge-qualified store strobe.
module data_bus_uart #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  data_bus_uart_if.slave  bus,
  output logic            uart_tx,
  output logic            tx_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BitLast = CW'(CLKS_PER_BIT - 1);

  localparam logic [15:0] AddrTxData = 16'hFF00;
  localparam logic [15:0] AddrStatus = 16'hFF01;
  localparam logic [15:0] AddrCycle  = 16'hFF02;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic          wr_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic          wr_stb;
  logic          in_ram;
  logic          tx_wr;
  logic          stat_wr;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   cycle_q;
  state_e        state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q;

  // The CPU holds mem_write for several cycles; commit only when the request is new.
  assign wr_stb  = bus.mem_write_in &
                   (~wr_q | (bus.mem_addr_in != addr_q) | (bus.mem_data_in != data_q));
  assign in_ram  = 32'(bus.mem_addr_in) < DEPTH;
  assign tx_wr   = wr_stb & (bus.mem_addr_in == AddrTxData);
  assign stat_wr = wr_stb & (bus.mem_addr_in == AddrStatus);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= bus.mem_write_in;
      addr_q <= bus.mem_addr_in;
      data_q <= bus.mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_stb && in_ram) begin
      mem[bus.mem_addr_in[AW-1:0]] <= bus.mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      // A TXDATA write is accepted only in StIdle; anything else is an overrun.
      if (tx_wr && (state_q != StIdle)) begin
        ovf_q <= 1'b1;
      end else if (stat_wr) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (tx_wr) begin
            shift_q   <= bus.mem_data_in[7:0];
            state_q   <= StStart;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
            state_q   <= StData;
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        StData: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        StStop: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_busy = (state_q != StIdle);
  assign uart_tx = tx_q;

  always_comb begin
    bus.data_out = '0;
    if (bus.mem_read_in) begin
      if (in_ram) begin
        bus.data_out = mem[bus.mem_addr_in[AW-1:0]];
      end else if (bus.mem_addr_in == AddrStatus) begin
        bus.data_out = {14'b0, ovf_q, tx_busy};
      end else if (bus.mem_addr_in == AddrCycle) begin
        bus.data_out = cycle_q;
      end
    end
  end

endmodule
